// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard controller: per-register latency countdowns drive the decode/execute stall, flush and halt-drain controls.
// Optional saturating stall-cycle counter is built only when HAZARD_PERF_EN is defined.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3,
    parameter int PERF_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_regwr,
    input  logic [REG_AW-1:0] id_wsel,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              branch_flush,
    input  logic              jump_flush,
    output logic              IFID_enable,
    output logic              IFID_flush,
    output logic              IDEX_enable,
    output logic              IDEX_flush,
    output logic              pcWEN,
    output logic              halt_out,
    output logic [REG_AW:0]   pending,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int NREG = 2 ** REG_AW;
    localparam logic [LAT_W-1:0] CNT_MAX = '1;
    localparam logic [LAT_W-1:0] LAT_ONE = 1;
    localparam logic [REG_AW:0]  PEND_ONE = 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t state_q, state_d;
    logic [NREG-1:0][LAT_W-1:0] cnt_q, cnt_d;

    logic flush, adv, raw, waw, hz, issue;
    logic [LAT_W-1:0] lat_inc;
    logic [REG_AW:0]  pend_cnt;

    always_comb begin
        flush = branch_flush | jump_flush;
        adv   = ihit | dhit;
        raw   = (id_use_rs && id_rs != '0 && cnt_q[id_rs] != '0) ||
                (id_use_rt && id_rt != '0 && cnt_q[id_rt] != '0);
        // A younger write may go ahead once the older one lands no later than it does.
        waw   = id_regwr && id_wsel != '0 && cnt_q[id_wsel] > id_lat;
        hz    = raw | waw;
        issue = (state_q == S_RUN) && ihit && !hz && !flush && !id_halt;
        lat_inc = (id_lat == CNT_MAX) ? CNT_MAX : id_lat + LAT_ONE;

        pend_cnt = '0;
        for (int i = 1; i < NREG; i++) begin
            if (cnt_q[i] != '0) pend_cnt = pend_cnt + PEND_ONE;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != S_HALTED) begin
            if (adv) begin
                for (int i = 1; i < NREG; i++) begin
                    if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - LAT_ONE;
                end
            end
            if (issue && id_regwr && id_wsel != '0) cnt_d[id_wsel] = lat_inc;
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (ihit && id_halt && !flush) state_d = S_DRAIN;
            S_DRAIN:  if (pend_cnt == '0) state_d = S_HALTED;
            default:  state_d = S_HALTED;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Controls follow hz in the same cycle, so they are decoded from state, not registered.
    always_comb begin
        IFID_enable = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_enable = 1'b0;
        IDEX_flush  = 1'b0;
        pcWEN       = 1'b0;
        halt_out    = 1'b0;
        if (!RST) begin
            case (state_q)
                S_RUN: begin
                    IFID_enable = ihit & ~hz;
                    IFID_flush  = flush;
                    IDEX_enable = ihit;
                    IDEX_flush  = hz | flush;
                    pcWEN       = ihit & ~hz;
                end
                S_DRAIN: begin
                    IDEX_enable = ihit;
                    IDEX_flush  = 1'b1;
                end
                default: halt_out = 1'b1;
            endcase
        end
    end

    assign pending = RST ? '0 : pend_cnt;

`ifdef HAZARD_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ONE = 1;
    logic [PERF_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_RUN && ihit && hz && !flush && stall_q != '1)
            stall_d = stall_q + PERF_ONE;
    end

    always_ff @(posedge CLK) begin
        if (RST) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = RST ? '0 : stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
